// File: rtl/dec2bin_pkg.sv
// dec2bin_pkg: state codes, widths and the shift-add times-ten helper for bcd_entry_to_bin.
package dec2bin_pkg;
   localparam int BIN_W = 7;
   localparam logic [3:0] MAX_DIGIT = 4'd9;
   typedef enum logic [1:0] {
      TENS  = 2'd0,
      UNITS = 2'd1,
      DONE  = 2'd2,
      ERR   = 2'd3
   } state_t;
   function automatic logic [BIN_W-1:0] times_ten(input logic [3:0] t);
      logic [BIN_W-1:0] w;
      w = BIN_W'(t);
      return (w << 3) + (w << 1);
   endfunction
endpackage

// File: rtl/key_sync_edge.sv
// key_sync_edge: 2-flop synchroniser, optional debounce (DEC_DEBOUNCE_EN), falling-edge press pulse.
module key_sync_edge #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic fr_CLK,
   input  logic fr_RST_N,
   input  logic fr_KEY_N,
   output logic press
);
   logic s1, s2, lvl, last;
   always_ff @(posedge fr_CLK or negedge fr_RST_N)
      if (!fr_RST_N) begin
         s1   <= 1'b1;
         s2   <= 1'b1;
         last <= 1'b1;
      end else begin
         s1   <= fr_KEY_N;
         s2   <= s1;
         last <= lvl;
      end
`ifdef DEC_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [CW-1:0] cnt;
   // lvl follows s2 only after it has disagreed for DEBOUNCE_CYCLES samples in a row
   always_ff @(posedge fr_CLK or negedge fr_RST_N)
      if (!fr_RST_N) begin
         cnt <= '0;
         lvl <= 1'b1;
      end else if (s2 == lvl) begin
         cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
         cnt <= '0;
         lvl <= s2;
      end else begin
         cnt <= cnt + 1'b1;
      end
`else
   assign lvl = s2;
`endif
   assign press = last & ~lvl;
endmodule

// File: rtl/bcd_entry_to_bin.sv
// bcd_entry_to_bin: two-digit BCD key entry converted to binary 0..99.
// Define DEC_DEBOUNCE_EN to debounce the enter key for DEBOUNCE_CYCLES samples.
import dec2bin_pkg::*;
module bcd_entry_to_bin #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic             fr_CLK,
   input  logic             fr_RST_N,
   input  logic [3:0]       fr_SW,
   input  logic             fr_KEY_N,
   input  logic             fr_CLR,
   output logic [BIN_W-1:0] to_BIN,
   output logic             to_VALID,
   output logic             to_ERR,
   output logic [1:0]       to_STATE
);
   logic press, bad;
   logic [3:0] tens;
   state_t state;
   key_sync_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .fr_CLK  (fr_CLK),
      .fr_RST_N(fr_RST_N),
      .fr_KEY_N(fr_KEY_N),
      .press   (press)
   );
   assign bad      = fr_SW > MAX_DIGIT;
   assign to_STATE = state;
   // DONE behaves like TENS on a press, but to_BIN is held until the next completion
   always_ff @(posedge fr_CLK or negedge fr_RST_N)
      if (!fr_RST_N) begin
         state    <= TENS;
         tens     <= '0;
         to_BIN   <= '0;
         to_VALID <= 1'b0;
         to_ERR   <= 1'b0;
      end else if (fr_CLR) begin
         state    <= TENS;
         tens     <= '0;
         to_BIN   <= '0;
         to_VALID <= 1'b0;
         to_ERR   <= 1'b0;
      end else if (press && state != ERR) begin
         if (bad) begin
            state    <= ERR;
            to_ERR   <= 1'b1;
            to_VALID <= 1'b0;
         end else if (state == UNITS) begin
            to_BIN   <= times_ten(tens) + BIN_W'(fr_SW);
            to_VALID <= 1'b1;
            state    <= DONE;
         end else begin
            tens     <= fr_SW;
            to_VALID <= 1'b0;
            state    <= UNITS;
         end
      end
endmodule

// File: doc/bcd_entry_to_bin.md
BCD_ENTRY_TO_BIN -- requirements
Module: bcd_entry_to_bin

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: number of consecutive stable samples required to accept a key level change (used only with DEC_DEBOUNCE_EN).
REQ-002 SHALL have port fr_CLK  in  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port fr_RST_N  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port fr_SW  in  4  current decimal digit, BCD; may be asynchronous, sampled on a recognised press only.
REQ-005 SHALL have port fr_KEY_N  in  1  enter key, active-low, asynchronous.
REQ-006 SHALL have port fr_CLR  in  1  synchronous clear, active-high.
REQ-007 SHALL have port to_BIN  out  7  binary value of the two-digit entry, 0..99.
REQ-008 SHALL have port to_VALID  out  1  to_BIN holds a completed entry.
REQ-009 SHALL have port to_ERR  out  1  a non-BCD digit (10..15) was entered.
REQ-010 SHALL have port to_STATE  out  2  FSM state code for LEDs: TENS=0, UNITS=1, DONE=2, ERR=3.

Function
REQ-011 fr_KEY_N SHALL pass through a 2-flop synchroniser; a press SHALL be a single-cycle pulse on the synchronised high-to-low transition.
REQ-012 Without DEC_DEBOUNCE_EN, fr_KEY_N low first sampled at rising edge N SHALL update FSM and outputs at edge N+2 (press pulse high between edges N+1 and N+2).
REQ-013 Holding fr_KEY_N low SHALL generate exactly one press; a further press needs release then re-press.
REQ-014 State TENS: on press, fr_SW<=9 -> store tens digit, go UNITS; fr_SW>9 -> go ERR, to_ERR=1.
REQ-015 State UNITS: on press, fr_SW<=9 -> to_BIN = tens*10 + fr_SW, to_VALID=1, go DONE; fr_SW>9 -> go ERR, to_ERR=1, to_BIN unchanged.
REQ-016 tens*10 SHALL be computed as (tens<<3)+(tens<<1) at 7-bit width; no truncation possible (max 99).
REQ-017 State DONE: to_BIN and to_VALID held; on press, act as TENS with fr_SW (new tens digit, to_VALID=0, to_BIN held until new completion), or go ERR if fr_SW>9.
REQ-018 State ERR: presses ignored; to_ERR held 1; only fr_CLR or reset exits.
REQ-019 fr_CLR=1 at a rising edge SHALL, from any state, go TENS, clear tens, to_BIN=0, to_VALID=0, to_ERR=0; fr_CLR SHALL win over a coincident press.
REQ-020 Entering ERR SHALL clear to_VALID to 0.
REQ-021 All outputs SHALL be registered; to_STATE SHALL equal the current state code.

Reset
REQ-022 fr_RST_N low SHALL immediately force state TENS, to_BIN=0, to_VALID=0, to_ERR=0, to_STATE=0, tens=0, synchroniser/debounce flops to released (1).
REQ-023 Reset asserted mid-entry SHALL discard a stored tens digit; no press SHALL be generated by reset release while fr_KEY_N is high.

Configuration
REQ-024 Macro DEC_DEBOUNCE_EN defined: synchronised key level SHALL be accepted only after DEBOUNCE_CYCLES consecutive equal samples; glitches shorter than that SHALL produce no press; latency grows by DEBOUNCE_CYCLES edges.
REQ-025 Macro DEC_DEBOUNCE_EN undefined: no debounce counter instantiated; timing per REQ-012.

Structure
REQ-026 Package dec2bin_pkg SHALL hold the state enum (TENS, UNITS, DONE, ERR and codes), BIN_W=7, MAX_DIGIT=9.
REQ-027 One sub-module, key_sync_edge, SHALL contain synchroniser, optional debounce and falling-edge pulse generator.

Verification
REQ-028 Reset, fr_SW=4 press, fr_SW=2 press -> to_BIN=42, to_VALID=1, to_STATE=2 at edge N+2 of second press.
REQ-029 fr_SW=9 press, fr_SW=9 press -> to_BIN=99; then fr_SW=0 press, fr_SW=7 press -> to_VALID low after first, to_BIN=7 after second.
REQ-030 fr_SW=3 press, fr_SW=12 press -> to_ERR=1, to_STATE=3, to_VALID=0; further presses no change; fr_CLR -> all outputs 0, to_STATE=0.
REQ-031 fr_KEY_N held low 50 cycles -> exactly one press; fr_CLR and press in same cycle -> state TENS, no digit stored.
REQ-032 fr_SW=5 press then fr_RST_N pulse low mid-cycle -> outputs 0 asynchronously; next fr_SW=1, fr_SW=6 presses -> to_BIN=16.
REQ-033 With DEC_DEBOUNCE_EN, DEBOUNCE_CYCLES=16: 10-cycle low glitch -> no press; 20-cycle low -> one press.
